// File: rtl/rx_block_lock_if.sv
// Gearbox-side signal bundle for the 64b/66b block lock monitor.
// slave is the lock monitor's view, master is the gearbox/stimulus side.
interface rx_block_lock_if;
    logic [1:0] xver_rx_header;
    logic       xver_rx_gearbox_valid;
    logic       xver_rx_gearbox_slip;
    logic       o_block_lock;
    logic       o_sh_err;

    modport master (
        output xver_rx_header,
        output xver_rx_gearbox_valid,
        input  xver_rx_gearbox_slip,
        input  o_block_lock,
        input  o_sh_err
    );

    modport slave (
        input  xver_rx_header,
        input  xver_rx_gearbox_valid,
        output xver_rx_gearbox_slip,
        output o_block_lock,
        output o_sh_err
    );
endinterface

// File: rtl/rx_block_lock.sv
// 64b/66b block lock FSM: hunts for LOCK_COUNT good sync headers, monitors errors per window
// while locked, and requests single-cycle gearbox slips followed by a settle period.
module rx_block_lock #(
    parameter int unsigned LOCK_COUNT       = 64,
    parameter int unsigned ERR_WINDOW       = 64,
    parameter int unsigned ERR_LIMIT        = 16,
    parameter int unsigned SLIP_WAIT_CYCLES = 32
) (
    input logic            xver_rx_clk,
    input logic            i_rx_reset_n,
    rx_block_lock_if.slave rx
);

    localparam int unsigned SH_MAX = (LOCK_COUNT > ERR_WINDOW) ? LOCK_COUNT : ERR_WINDOW;
    localparam int unsigned SH_W   = $clog2(SH_MAX + 1);
    localparam int unsigned ERR_W  = $clog2(ERR_LIMIT + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);

    localparam logic [SH_W-1:0]   LOCK_LAST = SH_W'(LOCK_COUNT - 1);
    localparam logic [SH_W-1:0]   WIN_LAST  = SH_W'(ERR_WINDOW - 1);
    localparam logic [ERR_W-1:0]  ERR_LAST  = ERR_W'(ERR_LIMIT - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        StHunt,
        StSlipWait,
        StLocked
    } state_e;

    state_e            state_q;
    logic [SH_W-1:0]   sh_cnt_q;
    logic [ERR_W-1:0]  err_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              block_lock_q;
    logic              slip_q;
    logic              sh_err_q;

    // Valid sync headers are exactly 2'b01 and 2'b10.
    logic hdr_ok;
    assign hdr_ok = rx.xver_rx_header[1] ^ rx.xver_rx_header[0];

    always_ff @(posedge xver_rx_clk or negedge i_rx_reset_n) begin
        if (!i_rx_reset_n) begin
            state_q      <= StHunt;
            sh_cnt_q     <= '0;
            err_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            block_lock_q <= 1'b0;
            slip_q       <= 1'b0;
            sh_err_q     <= 1'b0;
        end else begin
            slip_q   <= 1'b0;
            sh_err_q <= 1'b0;
            unique case (state_q)
                StHunt: begin
                    if (rx.xver_rx_gearbox_valid) begin
                        if (!hdr_ok) begin
                            sh_cnt_q   <= '0;
                            slip_q     <= 1'b1;
                            sh_err_q   <= 1'b1;
                            wait_cnt_q <= '0;
                            state_q    <= StSlipWait;
                        end else if (sh_cnt_q == LOCK_LAST) begin
                            sh_cnt_q     <= '0;
                            err_cnt_q    <= '0;
                            block_lock_q <= 1'b1;
                            state_q      <= StLocked;
                        end else begin
                            sh_cnt_q <= sh_cnt_q + SH_W'(1);
                        end
                    end
                end
                StSlipWait: begin
                    // Settle time for the gearbox; headers are ignored, valid or not.
                    if (wait_cnt_q == WAIT_LAST) begin
                        wait_cnt_q <= '0;
                        state_q    <= StHunt;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                StLocked: begin
                    if (rx.xver_rx_gearbox_valid) begin
                        sh_err_q <= !hdr_ok;
                        // Error limit takes priority over a coincident window end.
                        if (!hdr_ok && err_cnt_q == ERR_LAST) begin
                            block_lock_q <= 1'b0;
                            slip_q       <= 1'b1;
                            sh_cnt_q     <= '0;
                            err_cnt_q    <= '0;
                            wait_cnt_q   <= '0;
                            state_q      <= StSlipWait;
                        end else if (sh_cnt_q == WIN_LAST) begin
                            sh_cnt_q  <= '0;
                            err_cnt_q <= '0;
                        end else begin
                            sh_cnt_q <= sh_cnt_q + SH_W'(1);
                            if (!hdr_ok) begin
                                err_cnt_q <= err_cnt_q + ERR_W'(1);
                            end
                        end
                    end
                end
                default: state_q <= StHunt;
            endcase
        end
    end

    assign rx.o_block_lock         = block_lock_q;
    assign rx.xver_rx_gearbox_slip = slip_q;
    assign rx.o_sh_err             = sh_err_q;

endmodule

// File: tb/tb_rx_block_lock.sv
// Self-checking bench for rx_block_lock: directed scenarios plus randomized traffic
// compared cycle-by-cycle against a run/window/countdown reference model.
module tb_rx_block_lock;

    localparam int LOCK_N = 64;
    localparam int WIN_N  = 64;
    localparam int ERR_N  = 16;
    localparam int WAIT_N = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    rx_block_lock_if bus ();

    rx_block_lock #(
        .LOCK_COUNT      (LOCK_N),
        .ERR_WINDOW      (WIN_N),
        .ERR_LIMIT       (ERR_N),
        .SLIP_WAIT_CYCLES(WAIT_N)
    ) dut (
        .xver_rx_clk (clk),
        .i_rx_reset_n(rst_n),
        .rx          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: good-header run length, window tallies, remaining ignore cycles.
    int run, win_hdrs, win_errs, ignore_left;
    bit m_locked, m_slip, m_err;
    bit bad_pos[WIN_N];

    task automatic model_reset();
        run = 0; win_hdrs = 0; win_errs = 0; ignore_left = 0;
        m_locked = 0; m_slip = 0; m_err = 0;
    endtask

    task automatic model_edge(input logic [1:0] h, input logic v);
        bit good;
        good = (h == 2'b01) || (h == 2'b10);
        m_slip = 0;
        m_err = 0;
        if (ignore_left > 0) begin
            ignore_left--;
        end else if (v) begin
            if (!m_locked) begin
                if (good) begin
                    run++;
                    if (run == LOCK_N) begin
                        m_locked = 1; run = 0; win_hdrs = 0; win_errs = 0;
                    end
                end else begin
                    run = 0; m_slip = 1; m_err = 1; ignore_left = WAIT_N;
                end
            end else begin
                win_hdrs++;
                if (!good) begin
                    win_errs++;
                    m_err = 1;
                end
                if (win_errs == ERR_N) begin
                    m_locked = 0; m_slip = 1; ignore_left = WAIT_N;
                    run = 0; win_hdrs = 0; win_errs = 0;
                end else if (win_hdrs == WIN_N) begin
                    win_hdrs = 0; win_errs = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [1:0] h, input logic v);
        @(negedge clk);
        bus.xver_rx_header = h;
        bus.xver_rx_gearbox_valid = v;
        @(posedge clk);
        model_edge(h, v);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.xver_rx_header = 2'b00;
        bus.xver_rx_gearbox_valid = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(1) == 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic place_bad(input int n);
        int placed = 0;
        int p;
        for (int i = 0; i < WIN_N; i++) bad_pos[i] = 0;
        while (placed < n) begin
            p = $urandom_range(WIN_N - 1);
            if (!bad_pos[p]) begin
                bad_pos[p] = 1;
                placed++;
            end
        end
    endtask

    task automatic test_reset();
        bus.xver_rx_header = 2'b01;
        bus.xver_rx_gearbox_valid = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_block_lock, bus.xver_rx_gearbox_slip, bus.o_sh_err} !== 3'b000)
            $display("FAIL reset_async: got %b expected 000",
                     {bus.o_block_lock, bus.xver_rx_gearbox_slip, bus.o_sh_err});
        else passes++;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.o_block_lock, bus.xver_rx_gearbox_slip, bus.o_sh_err} !== 3'b000)
            $display("FAIL reset_hold: got %b expected 000",
                     {bus.o_block_lock, bus.xver_rx_gearbox_slip, bus.o_sh_err});
        else passes++;
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic acquire_lock();
        do_reset();
        for (int k = 1; k <= LOCK_N; k++) begin
            step(good_hdr(), 1'b1);
            checks++;
            if (bus.o_block_lock !== (k == LOCK_N) || bus.xver_rx_gearbox_slip !== 1'b0)
                $display("FAIL acquire k=%0d: got lock=%b slip=%b expected lock=%b slip=0",
                         k, bus.o_block_lock, bus.xver_rx_gearbox_slip, k == LOCK_N);
            else passes++;
        end
    endtask

    task automatic test_slip_period();
        int slips = 0, errs = 0;
        do_reset();
        for (int k = 1; k <= 100; k++) begin
            step(2'b00, 1'b1);
            slips += int'(bus.xver_rx_gearbox_slip);
            errs += int'(bus.o_sh_err);
            checks++;
            if (bus.xver_rx_gearbox_slip !== ((k - 1) % 33 == 0) || bus.o_block_lock !== 1'b0)
                $display("FAIL slip_period k=%0d: got slip=%b lock=%b expected slip=%b lock=0",
                         k, bus.xver_rx_gearbox_slip, bus.o_block_lock, (k - 1) % 33 == 0);
            else passes++;
        end
        checks++;
        if (slips != 4 || errs != 4)
            $display("FAIL slip_counts: got slips=%0d sh_errs=%0d expected 4 and 4", slips, errs);
        else passes++;
    endtask

    task automatic test_err_window(input int nbad);
        acquire_lock();
        place_bad(nbad);
        for (int i = 0; i < WIN_N; i++) begin
            step(bad_pos[i] ? bad_hdr() : good_hdr(), 1'b1);
            checks++;
            if ({bus.o_block_lock, bus.xver_rx_gearbox_slip, bus.o_sh_err} !==
                {1'b1, 1'b0, bad_pos[i]})
                $display("FAIL err15 i=%0d: got %b expected %b", i,
                         {bus.o_block_lock, bus.xver_rx_gearbox_slip, bus.o_sh_err},
                         {1'b1, 1'b0, bad_pos[i]});
            else passes++;
        end
    endtask

    task automatic test_loss_of_lock();
        int nth = 0;
        acquire_lock();
        place_bad(ERR_N);
        for (int i = 0; i < WIN_N && nth < ERR_N; i++) begin
            if (bad_pos[i]) nth++;
            step(bad_pos[i] ? bad_hdr() : good_hdr(), 1'b1);
            checks++;
            if ({bus.o_block_lock, bus.xver_rx_gearbox_slip} !== {nth < ERR_N, nth == ERR_N})
                $display("FAIL loss i=%0d: got lock/slip=%b expected %b", i,
                         {bus.o_block_lock, bus.xver_rx_gearbox_slip},
                         {nth < ERR_N, nth == ERR_N});
            else passes++;
        end
        for (int k = 0; k < WAIT_N; k++) begin
            step(bad_hdr(), 1'b1);
            checks++;
            if ({bus.o_block_lock, bus.xver_rx_gearbox_slip, bus.o_sh_err} !== 3'b000)
                $display("FAIL slip_wait k=%0d: got %b expected 000", k,
                         {bus.o_block_lock, bus.xver_rx_gearbox_slip, bus.o_sh_err});
            else passes++;
        end
        step(bad_hdr(), 1'b1);
        checks++;
        if ({bus.xver_rx_gearbox_slip, bus.o_sh_err} !== 2'b11)
            $display("FAIL after_wait: got slip/sh_err=%b expected 11",
                     {bus.xver_rx_gearbox_slip, bus.o_sh_err});
        else passes++;
    endtask

    task automatic test_four_windows();
        acquire_lock();
        for (int w = 0; w < 4; w++) begin
            place_bad(ERR_N - 1);
            for (int i = 0; i < WIN_N; i++) begin
                step(bad_pos[i] ? bad_hdr() : good_hdr(), 1'b1);
                checks++;
                if ({bus.o_block_lock, bus.o_sh_err} !== {1'b1, bad_pos[i]})
                    $display("FAIL windows w=%0d i=%0d: got lock/sh_err=%b expected %b", w, i,
                             {bus.o_block_lock, bus.o_sh_err}, {1'b1, bad_pos[i]});
                else passes++;
            end
        end
    endtask

    task automatic test_toggle_valid();
        do_reset();
        for (int k = 1; k <= 130; k++) begin
            step(good_hdr(), k[0]);
            checks++;
            if (bus.o_block_lock !== (k >= 127))
                $display("FAIL toggle k=%0d: got lock=%b expected %b", k, bus.o_block_lock,
                         k >= 127);
            else passes++;
        end
    endtask

    task automatic test_async_reset();
        acquire_lock();
        step(good_hdr(), 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_block_lock, bus.xver_rx_gearbox_slip} !== 2'b00)
            $display("FAIL async_drop: got lock/slip=%b expected 00",
                     {bus.o_block_lock, bus.xver_rx_gearbox_slip});
        else passes++;
        // Abort a slip pulse in flight, then check the first edge after release.
        do_reset();
        step(2'b00, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.xver_rx_gearbox_slip, bus.o_sh_err} !== 2'b00)
            $display("FAIL abort_slip: got slip/sh_err=%b expected 00",
                     {bus.xver_rx_gearbox_slip, bus.o_sh_err});
        else passes++;
        @(negedge clk);
        model_reset();
        bus.xver_rx_header = 2'b11;
        bus.xver_rx_gearbox_valid = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        model_edge(2'b11, 1'b1);
        #1;
        checks++;
        if ({bus.xver_rx_gearbox_slip, bus.o_sh_err} !== 2'b11)
            $display("FAIL first_edge: got slip/sh_err=%b expected 11",
                     {bus.xver_rx_gearbox_slip, bus.o_sh_err});
        else passes++;
        // Abort mid slip-wait; HUNT must respond with no leftover slip.
        repeat (5) step(2'b00, 1'b1);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(k < 3 ? 2'b00 : 2'b01, k == 3);
            checks++;
            if ({bus.xver_rx_gearbox_slip, bus.o_sh_err} !== 2'b00)
                $display("FAIL abort_wait k=%0d: got slip/sh_err=%b expected 00", k,
                         {bus.xver_rx_gearbox_slip, bus.o_sh_err});
            else passes++;
        end
    endtask

    task automatic test_random();
        int rates[4] = '{0, 200, 12, 3};
        int rate;
        logic v, prev_slip;
        do_reset();
        prev_slip = 1'b0;
        for (int ph = 0; ph < 10; ph++) begin
            rate = rates[$urandom_range(3)];
            for (int k = 0; k < 300; k++) begin
                v = ($urandom_range(3) != 0);
                step((rate != 0 && $urandom_range(rate - 1) == 0) ? bad_hdr() : good_hdr(), v);
                checks++;
                if ({bus.o_block_lock, bus.xver_rx_gearbox_slip, bus.o_sh_err} !==
                    {m_locked, m_slip, m_err} || (prev_slip && bus.xver_rx_gearbox_slip))
                    $display("FAIL random ph=%0d k=%0d: got %b expected %b", ph, k,
                             {bus.o_block_lock, bus.xver_rx_gearbox_slip, bus.o_sh_err},
                             {m_locked, m_slip, m_err});
                else passes++;
                prev_slip = bus.xver_rx_gearbox_slip;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        acquire_lock();
        test_slip_period();
        test_err_window(ERR_N - 1);
        test_loss_of_lock();
        test_four_windows();
        test_toggle_valid();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
